// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: register map, FSM encoding, requester count.
package uart_pkg;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned GNT_W = $clog2(NREQ);
   localparam int unsigned REG_W = 2;

   // UART CSR register indices within the bank
   typedef enum logic [REG_W-1:0] {
      REG_RXTX    = 2'b00,
      REG_DIVISOR = 2'b01,
      REG_THRU    = 2'b10,
      REG_CTRL    = 2'b11
   } uart_reg_e;

   localparam logic [1:0] ST_CFG_ENC  = 2'd0;
   localparam logic [1:0] ST_ARB_ENC  = 2'd1;
   localparam logic [1:0] ST_SEND_ENC = 2'd2;
   localparam logic [1:0] ST_WAIT_ENC = 2'd3;

   typedef enum logic [1:0] {
      ST_CFG  = ST_CFG_ENC,
      ST_ARB  = ST_ARB_ENC,
      ST_SEND = ST_SEND_ENC,
      ST_WAIT = ST_WAIT_ENC
   } state_e;

   // One-hot mask of a requester index
   function automatic logic [NREQ-1:0] onehot(input logic [GNT_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin picker: first eligible requester after the pointer, wrapping.
module rr_arbiter4
   import uart_pkg::*;
(
   input  logic [NREQ-1:0]  eligible,
   input  logic [GNT_W-1:0] pointer,
   output logic [GNT_W-1:0] winner,
   output logic             any
);

   logic [GNT_W-1:0] idx;

   // Scan farthest-to-nearest so the nearest eligible slot after the pointer is the last one kept
   always_comb begin
      winner = pointer;
      any    = 1'b0;
      idx    = pointer;
      for (int k = NREQ; k >= 1; k--) begin
         idx = pointer + GNT_W'(k);
         if (eligible[idx]) begin
            winner = idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among four byte streams; sole CSR master of that UART.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter logic [3:0]  csr_addr   = 4'h0,
   parameter int unsigned tx_timeout = 200000
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [8*NREQ-1:0]    req_data,
   input  logic [NREQ-1:0]      req_last,
   output logic [NREQ-1:0]      req_ready,
   input  logic [15:0]          cfg_divisor,
   input  logic                 cfg_req,
   input  logic                 tx_irq,
   output logic [14:0]          csr_a,
   output logic                 csr_we,
   output logic [31:0]          csr_di,
   output logic [GNT_W-1:0]     grant,
   output logic                 busy,
   output logic                 timeout_err,
   input  logic                 err_clr
);

   localparam int unsigned           WDOG_W    = $clog2(tx_timeout);
   localparam logic [WDOG_W-1:0]     WDOG_LAST = WDOG_W'(tx_timeout - 1);

   state_e            state_q, state_d;
   logic [GNT_W-1:0]  grant_q, grant_d;
   logic [GNT_W-1:0]  ptr_q, ptr_d;
   logic              lock_q, lock_d;
   logic              cfg_pend_q, cfg_pend_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic [NREQ-1:0]   req_ready_q, req_ready_d;
   logic              csr_we_q, csr_we_d;
   uart_reg_e         csr_reg_q, csr_reg_d;
   logic [31:0]       csr_di_q, csr_di_d;
   logic              busy_q, busy_d;
   logic              timeout_err_q, timeout_err_d;

   logic [NREQ-1:0]   eligible;
   logic [GNT_W-1:0]  arb_winner;
   logic              arb_any;
   logic [7:0]        owner_byte;

   // While a packet is open only its owner may compete
   assign eligible   = lock_q ? (onehot(grant_q) & req_valid) : req_valid;
   assign owner_byte = req_data[{grant_q, 3'b000} +: 8];

   rr_arbiter4 u_arb (
      .eligible (eligible),
      .pointer  (ptr_q),
      .winner   (arb_winner),
      .any      (arb_any)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      ptr_d         = ptr_q;
      lock_d        = lock_q;
      cfg_pend_d    = cfg_pend_q | cfg_req;
      wdog_d        = wdog_q;
      req_ready_d   = '0;
      csr_we_d      = 1'b0;
      csr_reg_d     = csr_reg_q;
      csr_di_d      = csr_di_q;
      timeout_err_d = err_clr ? 1'b0 : timeout_err_q;

      unique case (state_q)
         ST_CFG: begin
            csr_we_d  = 1'b1;
            csr_reg_d = REG_DIVISOR;
            csr_di_d  = {16'd0, cfg_divisor};
            state_d   = ST_ARB;
         end
         ST_ARB: begin
            if (cfg_pend_q && !lock_q) begin
               cfg_pend_d = cfg_req;
               state_d    = ST_CFG;
            end else if (arb_any) begin
               grant_d = arb_winner;
               ptr_d   = arb_winner;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            // A requester that dropped valid early gets no write; re-arbitrate
            if (!req_valid[grant_q]) begin
               state_d = ST_ARB;
            end else begin
               csr_we_d    = 1'b1;
               csr_reg_d   = REG_RXTX;
               csr_di_d    = {24'd0, owner_byte};
               req_ready_d = onehot(grant_q);
               lock_d      = ~req_last[grant_q];
               wdog_d      = '0;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            wdog_d = wdog_q + WDOG_W'(1);
            if (tx_irq) begin
               state_d = ST_ARB;
            end else if (wdog_q == WDOG_LAST) begin
               timeout_err_d = 1'b1;
               lock_d        = 1'b0;
               state_d       = ST_ARB;
            end
         end
         default: state_d = ST_CFG;
      endcase

      busy_d = (state_d != ST_ARB) || lock_d;
   end

   // State and output registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= ST_CFG;
         grant_q       <= '0;
         ptr_q         <= GNT_W'(NREQ - 1);
         lock_q        <= 1'b0;
         cfg_pend_q    <= 1'b0;
         wdog_q        <= '0;
         req_ready_q   <= '0;
         csr_we_q      <= 1'b0;
         csr_reg_q     <= REG_RXTX;
         csr_di_q      <= '0;
         busy_q        <= 1'b1;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         ptr_q         <= ptr_d;
         lock_q        <= lock_d;
         cfg_pend_q    <= cfg_pend_d;
         wdog_q        <= wdog_d;
         req_ready_q   <= req_ready_d;
         csr_we_q      <= csr_we_d;
         csr_reg_q     <= csr_reg_d;
         csr_di_q      <= csr_di_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign csr_we      = csr_we_q;
   assign csr_a       = {1'b0, csr_addr, 8'd0, csr_reg_q};
   assign csr_di      = csr_di_q;
   assign grant       = grant_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule
